// File: rtl/codecracker_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : codecracker_timer_pkg
//  Purpose  : Shared definitions for the round timer: interval-timer register
//             map, control-register bit positions and the sequencer state type.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package codecracker_timer_pkg;

    // Interval-timer register addresses (16-bit registers)
    localparam logic [2:0] STATUS  = 3'd0;
    localparam logic [2:0] CONTROL = 3'd1;
    localparam logic [2:0] PERIODL = 3'd2;
    localparam logic [2:0] PERIODH = 3'd3;
    localparam logic [2:0] SNAPL   = 3'd4;
    localparam logic [2:0] SNAPH   = 3'd5;

    // Control register bit positions
    localparam int ITO   = 0;
    localparam int CONT  = 1;
    localparam int START = 2;
    localparam int STOP  = 3;

    // Control words written by the sequencer
    localparam logic [15:0] CTRL_RUN  = 16'((1 << ITO) | (1 << CONT) | (1 << START));
    localparam logic [15:0] CTRL_HALT = 16'(1 << STOP);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_PL,
        ST_WR_PH,
        ST_WR_CTRL,
        ST_RUN,
        ST_ACK,
        ST_HOLD,
        ST_WR_STOP
    } state_e;

endpackage
`default_nettype wire

// File: rtl/codecracker_round_timer_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : bcd_down_counter_3d
//  Purpose  : Three-digit BCD down counter. Loads a binary value (saturated to
//             999), decrements with borrow across digits, flags 000.
//  Ports    : clk, reset_n     clock, async active-low reset
//             load_i           load load_val_i (binary) this cycle
//             load_val_i[9:0]  binary value, >999 treated as 999
//             dec_i            decrement by one (ignored at 000)
//             bcd_o[11:0]      current value, hundreds in [11:8]
//             zero_o           bcd_o == 000
//  Revision : 1.0  initial release
// ============================================================================
module bcd_down_counter_3d (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        load_i,
    input  logic [9:0]  load_val_i,
    input  logic        dec_i,
    output logic [11:0] bcd_o,
    output logic        zero_o
);
    logic [11:0] bcd_q, bcd_d;
    logic [9:0]  sat_val;
    logic [3:0]  hund_bin, tens_bin, ones_bin;

    assign zero_o = (bcd_q == 12'h000);
    assign bcd_o  = bcd_q;

    always_comb begin
        sat_val  = (load_val_i > 10'd999) ? 10'd999 : load_val_i;
        hund_bin = 4'(sat_val / 10'd100);
        tens_bin = 4'((sat_val / 10'd10) % 10'd10);
        ones_bin = 4'(sat_val % 10'd10);

        bcd_d = bcd_q;
        if (load_i) begin
            bcd_d = {hund_bin, tens_bin, ones_bin};
        end else if (dec_i && !zero_o) begin
            if (bcd_q[3:0] != 4'd0) begin
                bcd_d[3:0] = bcd_q[3:0] - 4'd1;
            end else begin
                bcd_d[3:0] = 4'd9;
                if (bcd_q[7:4] != 4'd0) begin
                    bcd_d[7:4] = bcd_q[7:4] - 4'd1;
                end else begin
                    // non-zero value with x00 pattern: hundreds must be >0
                    bcd_d[7:4]  = 4'd9;
                    bcd_d[11:8] = bcd_q[11:8] - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q <= 12'h000;
        end else begin
            bcd_q <= bcd_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/codecracker_round_timer.sv
`default_nettype none
// ============================================================================
//  Module   : codecracker_round_timer
//  Purpose  : Avalon-MM master owning the interval timer; programs it, acks
//             each irq and turns TICKS_PER_SEC irqs into one BCD second of the
//             round countdown. Pulses expired when the count reaches 000.
//  Ports    : clk, reset_n            clock, async active-low reset
//             start, start_seconds    (re)start a round of 0..999 seconds
//             stop                    abort the round
//             running, expired        countdown active / 1-cycle expiry pulse
//             secs_bcd[11:0]          remaining seconds, 3 BCD digits
//             tmr_address/chipselect/write_n/writedata/waitrequest  timer bus
//             tmr_irq                 timer interrupt (level)
//  Revision : 1.0  initial release
// ============================================================================
module codecracker_round_timer
    import codecracker_timer_pkg::*;
#(
    parameter int PERIOD        = 50000,
    parameter int TICKS_PER_SEC = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [9:0]  start_seconds,
    input  logic        stop,
    output logic        running,
    output logic        expired,
    output logic [11:0] secs_bcd,
    output logic [2:0]  tmr_address,
    output logic        tmr_chipselect,
    output logic        tmr_write_n,
    output logic [15:0] tmr_writedata,
    input  logic        tmr_waitrequest,
    input  logic        tmr_irq
);
    localparam int               TICK_W      = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [31:0]      PERIOD_M1   = 32'(PERIOD - 1);

    state_e              state_q, state_d;
    logic                running_q, running_d;
    logic                expired_q, expired_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic                restart_pend_q, restart_pend_d;
    logic                stop_pend_q, stop_pend_d;

    logic bcd_load, bcd_dec, bcd_zero;
    logic start_zero, req_restart, req_stop, is_write, wr_done;

    bcd_down_counter_3d u_secs (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_i     (bcd_load),
        .load_val_i (start_seconds),
        .dec_i      (bcd_dec),
        .bcd_o      (secs_bcd),
        .zero_o     (bcd_zero)
    );

    assign running = running_q;
    assign expired = expired_q;

    // Bus signals decode straight from the registered state, so a reset drops
    // the bus in the same instant the state register clears.
    always_comb begin
        tmr_chipselect = 1'b0;
        tmr_write_n    = 1'b1;
        tmr_address    = STATUS;
        tmr_writedata  = 16'h0000;
        is_write       = 1'b1;
        case (state_q)
            ST_WR_PL:   begin tmr_address = PERIODL; tmr_writedata = PERIOD_M1[15:0];  end
            ST_WR_PH:   begin tmr_address = PERIODH; tmr_writedata = PERIOD_M1[31:16]; end
            ST_WR_CTRL: begin tmr_address = CONTROL; tmr_writedata = CTRL_RUN;         end
            ST_ACK:     begin tmr_address = STATUS;  tmr_writedata = 16'h0000;         end
            ST_WR_STOP: begin tmr_address = CONTROL; tmr_writedata = CTRL_HALT;        end
            default:    is_write = 1'b0;
        endcase
        if (is_write) begin
            tmr_chipselect = 1'b1;
            tmr_write_n    = 1'b0;
        end
    end

    always_comb begin
        state_d        = state_q;
        running_d      = running_q;
        expired_d      = 1'b0;
        tick_d         = tick_q;
        restart_pend_d = restart_pend_q;
        stop_pend_d    = stop_pend_q;
        bcd_load       = 1'b0;
        bcd_dec        = 1'b0;

        start_zero = (start_seconds == 10'd0);
        wr_done    = is_write && !tmr_waitrequest;

        // A fresh start overrides anything pending; a zero-length start acts
        // as an immediate expiry plus a stop of any active round.
        req_restart = start ? !start_zero : restart_pend_q;
        req_stop    = start ? start_zero  : (!restart_pend_q && (stop || stop_pend_q));

        if (start) begin
            bcd_load = 1'b1;
            tick_d   = TICK_RELOAD;
            if (start_zero) begin
                expired_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !start_zero) begin
                    state_d = ST_WR_PL;
                end
            end
            ST_RUN, ST_HOLD: begin
                if (req_restart) begin
                    state_d = ST_WR_PL;
                end else if (req_stop) begin
                    state_d = ST_WR_STOP;
                end else if (state_q == ST_RUN) begin
                    if (tmr_irq) begin
                        state_d = ST_ACK;
                    end
                end else if (bcd_zero) begin
                    state_d   = ST_WR_STOP;
                    expired_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (!wr_done) begin
                    restart_pend_d = req_restart;
                    stop_pend_d    = req_stop;
                end else begin
                    restart_pend_d = 1'b0;
                    stop_pend_d    = 1'b0;
                    if (req_restart) begin
                        state_d = ST_WR_PL;
                    end else if (req_stop && state_q != ST_WR_STOP) begin
                        state_d = ST_WR_STOP;
                    end else begin
                        case (state_q)
                            ST_WR_PL:   state_d = ST_WR_PH;
                            ST_WR_PH:   state_d = ST_WR_CTRL;
                            ST_WR_CTRL: begin
                                state_d   = ST_RUN;
                                running_d = 1'b1;
                            end
                            ST_ACK: begin
                                if (tick_q != '0) begin
                                    tick_d = tick_q - 1'b1;
                                end else begin
                                    tick_d  = TICK_RELOAD;
                                    bcd_dec = 1'b1;
                                end
                                state_d = ST_HOLD;
                            end
                            default: begin
                                state_d   = ST_IDLE;
                                running_d = 1'b0;
                            end
                        endcase
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            running_q      <= 1'b0;
            expired_q      <= 1'b0;
            tick_q         <= TICK_RELOAD;
            restart_pend_q <= 1'b0;
            stop_pend_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            running_q      <= running_d;
            expired_q      <= expired_d;
            tick_q         <= tick_d;
            restart_pend_q <= restart_pend_d;
            stop_pend_q    <= stop_pend_d;
        end
    end

endmodule
`default_nettype wire
